// File: rtl/pcs_pkg.sv
// Shared definitions for the 64b/66b receive block synchroniser.
//   HDR_DATA / HDR_CTRL : the two legal sync-header values
//   lock_state_e        : per-lane block-lock FSM states
//   hdr_valid()         : 1 when a sync header is one of the legal values
package pcs_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP_WAIT
  } lock_state_e;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_block_lock_lane.sv
// One lane of the receive block synchroniser: lock FSM, hi-BER monitor and
// saturating invalid-header counter. All outputs are registered.
//   clk, rst_n      : receive clock, async active-low reset
//   header, hdr_vld : sync header from the gearbox and its valid strobe
//   clear_counters  : synchronous clear of err_count (wins over increment)
//   slip            : one-cycle gearbox slip request
//   block_lock      : lane is block-locked
//   hi_ber          : too many invalid headers in the current BER window
//   err_count       : saturating count of evaluated invalid headers
module pcs_rx_block_lock_lane
  import pcs_pkg::*;
#(
  parameter int LOCK_COUNT    = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_CYCLES   = 32,
  parameter int BER_WINDOW    = 20000,
  parameter int BER_LIMIT     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] header,
  input  logic       hdr_vld,
  input  logic       clear_counters,
  output logic       slip,
  output logic       block_lock,
  output logic       hi_ber,
  output logic [7:0] err_count
);

  localparam int SH_W  = $clog2(LOCK_COUNT + 1);
  localparam int INV_W = $clog2(INVALID_LIMIT + 1);
  localparam int WIN_W = $clog2(BER_WINDOW);
  localparam int BER_W = $clog2(BER_LIMIT + 1);

  lock_state_e      state_q, state_d;
  logic [SH_W-1:0]  sh_q, sh_d, sh_inc;
  logic [INV_W-1:0] inv_q, inv_d, inv_inc;
  logic [7:0]       wait_q, wait_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [BER_W-1:0] ber_q, ber_d, ber_inc;
  logic             lock_d, slip_d, hi_ber_d, lose_lock;
  logic             bad, evaluate;
  logic [7:0]       err_d;

  always_comb begin
    bad      = ~hdr_valid(header);
    evaluate = hdr_vld & (state_q == TEST_SH);
    sh_inc   = sh_q + SH_W'(1);
    inv_inc  = inv_q + INV_W'(bad);

    state_d   = state_q;
    sh_d      = sh_q;
    inv_d     = inv_q;
    wait_d    = wait_q;
    lock_d    = block_lock;
    slip_d    = 1'b0;
    lose_lock = 1'b0;

    case (state_q)
      LOCK_INIT: begin
        sh_d    = '0;
        inv_d   = '0;
        state_d = TEST_SH;
      end
      TEST_SH: begin
        if (hdr_vld) begin
          if (!block_lock) begin
            // While hunting, any bad header means the boundary is wrong.
            if (bad) begin
              slip_d  = 1'b1;
              wait_d  = '0;
              state_d = SLIP_WAIT;
            end else if (sh_inc == SH_W'(LOCK_COUNT)) begin
              lock_d = 1'b1;
              sh_d   = '0;
              inv_d  = '0;
            end else begin
              sh_d = sh_inc;
            end
          end else begin
            // Loss of lock is checked first so it wins a same-header tie
            // with the end of the LOCK_COUNT window.
            if (inv_inc == INV_W'(INVALID_LIMIT)) begin
              lose_lock = 1'b1;
              lock_d    = 1'b0;
              slip_d    = 1'b1;
              wait_d    = '0;
              state_d   = SLIP_WAIT;
            end else if (sh_inc == SH_W'(LOCK_COUNT)) begin
              sh_d  = '0;
              inv_d = '0;
            end else begin
              sh_d  = sh_inc;
              inv_d = inv_inc;
            end
          end
        end
      end
      SLIP_WAIT: begin
        // Counts every clock from the slip pulse, independent of hdr_vld.
        if (wait_q == 8'(SLIP_CYCLES - 1)) state_d = LOCK_INIT;
        else                                wait_d  = wait_q + 8'd1;
      end
      default: state_d = LOCK_INIT;
    endcase
  end

  // Hi-BER: window runs only while locked; the header on the last window
  // cycle still counts towards that window's verdict.
  always_comb begin
    ber_inc  = (ber_q == BER_W'(BER_LIMIT)) ? ber_q : ber_q + BER_W'(evaluate & bad);
    win_d    = win_q;
    ber_d    = ber_q;
    hi_ber_d = hi_ber;
    if (lose_lock || !block_lock) begin
      win_d    = '0;
      ber_d    = '0;
      hi_ber_d = 1'b0;
    end else if (win_q == WIN_W'(BER_WINDOW - 1)) begin
      win_d    = '0;
      ber_d    = '0;
      hi_ber_d = (ber_inc == BER_W'(BER_LIMIT));
    end else begin
      win_d = win_q + WIN_W'(1);
      ber_d = ber_inc;
      if (ber_inc == BER_W'(BER_LIMIT)) hi_ber_d = 1'b1;
    end
  end

  always_comb begin
    err_d = err_count;
    if (clear_counters)
      err_d = '0;
    else if (hdr_vld && bad && state_q != SLIP_WAIT && err_count != 8'hFF)
      err_d = err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCK_INIT;
      sh_q       <= '0;
      inv_q      <= '0;
      wait_q     <= '0;
      win_q      <= '0;
      ber_q      <= '0;
      slip       <= 1'b0;
      block_lock <= 1'b0;
      hi_ber     <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      inv_q      <= inv_d;
      wait_q     <= wait_d;
      win_q      <= win_d;
      ber_q      <= ber_d;
      slip       <= slip_d;
      block_lock <= lock_d;
      hi_ber     <= hi_ber_d;
      err_count  <= err_d;
    end
  end

endmodule

// File: rtl/pcs_rx_block_lock.sv
// Multi-lane 64b/66b receive block synchroniser. Slices the gearbox buses
// into independent lanes and reduces per-lane status into link-up.
//   xver_rx_clk, i_rx_reset_n : clock, async active-low reset
//   i_rx_header               : 2 bits per lane, lane n at [2n+1:2n]
//   i_rx_gearbox_valid        : per-lane header valid
//   i_clear_counters          : clears all error counters
//   o_rx_gearbox_slip         : per-lane one-cycle slip request
//   o_block_lock, o_hi_ber    : per-lane status
//   o_err_count               : 8 bits per lane, saturating
//   o_link_up                 : all lanes locked and none in hi-BER (one cycle later)
module pcs_rx_block_lock #(
  parameter int NUM_LANES     = 1,
  parameter int LOCK_COUNT    = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_WAIT     = 32,
  parameter int BER_WINDOW    = 20000,
  parameter int BER_LIMIT     = 16
) (
  input  logic                   xver_rx_clk,
  input  logic                   i_rx_reset_n,
  input  logic [2*NUM_LANES-1:0] i_rx_header,
  input  logic [NUM_LANES-1:0]   i_rx_gearbox_valid,
  input  logic                   i_clear_counters,
  output logic [NUM_LANES-1:0]   o_rx_gearbox_slip,
  output logic [NUM_LANES-1:0]   o_block_lock,
  output logic [NUM_LANES-1:0]   o_hi_ber,
  output logic [8*NUM_LANES-1:0] o_err_count,
  output logic                   o_link_up
);

  logic [NUM_LANES-1:0] lane_ok;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pcs_rx_block_lock_lane #(
      .LOCK_COUNT   (LOCK_COUNT),
      .INVALID_LIMIT(INVALID_LIMIT),
      .SLIP_CYCLES  (SLIP_WAIT),
      .BER_WINDOW   (BER_WINDOW),
      .BER_LIMIT    (BER_LIMIT)
    ) u_lane (
      .clk           (xver_rx_clk),
      .rst_n         (i_rx_reset_n),
      .header        (i_rx_header[2*g +: 2]),
      .hdr_vld       (i_rx_gearbox_valid[g]),
      .clear_counters(i_clear_counters),
      .slip          (o_rx_gearbox_slip[g]),
      .block_lock    (o_block_lock[g]),
      .hi_ber        (o_hi_ber[g]),
      .err_count     (o_err_count[8*g +: 8])
    );
  end

  assign lane_ok = o_block_lock & ~o_hi_ber;

  always_ff @(posedge xver_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) o_link_up <= 1'b0;
    else               o_link_up <= &lane_ok;
  end

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Scoreboard bench: the driver runs a behavioural lane model and queues the
// expected outputs; a monitor pops and compares after every clock edge.
module tb_pcs_rx_block_lock;

  localparam int NL            = 4;
  localparam int LOCK_COUNT    = 64;
  localparam int INVALID_LIMIT = 16;
  localparam int SLIP_WAIT     = 32;
  localparam int BER_WINDOW    = 20000;
  localparam int BER_LIMIT     = 16;
  localparam int VW            = 1 + 8*NL + 3*NL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2*NL-1:0]   hdr = '0;
  logic [NL-1:0]     vld = '0;
  logic              clr = 1'b0;
  logic [NL-1:0]     slip, lock, hiber;
  logic [8*NL-1:0]   errc;
  logic              link;

  always #5 clk = ~clk;

  pcs_rx_block_lock #(
    .NUM_LANES(NL), .LOCK_COUNT(LOCK_COUNT), .INVALID_LIMIT(INVALID_LIMIT),
    .SLIP_WAIT(SLIP_WAIT), .BER_WINDOW(BER_WINDOW), .BER_LIMIT(BER_LIMIT)
  ) u_dut (
    .xver_rx_clk(clk), .i_rx_reset_n(rst_n), .i_rx_header(hdr),
    .i_rx_gearbox_valid(vld), .i_clear_counters(clr),
    .o_rx_gearbox_slip(slip), .o_block_lock(lock), .o_hi_ber(hiber),
    .o_err_count(errc), .o_link_up(link)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];

  // ---- behavioural reference: phase 0 = init, 1 = testing, 2 = waiting
  int m_phase[NL], m_hdrs[NL], m_bad[NL], m_wait[NL];
  int m_age[NL], m_ber[NL], m_err[NL];
  bit m_lock[NL], m_hi[NL], m_slip[NL];
  bit m_link;

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_phase[l] = 0; m_hdrs[l] = 0; m_bad[l] = 0; m_wait[l] = 0;
      m_age[l] = 0; m_ber[l] = 0; m_err[l] = 0;
      m_lock[l] = 0; m_hi[l] = 0; m_slip[l] = 0;
    end
    m_link = 0;
  endtask

  task automatic model_step(input logic [2*NL-1:0] h, input logic [NL-1:0] v, input logic c);
    bit all_ok;
    all_ok = 1;
    for (int l = 0; l < NL; l++) all_ok = all_ok & m_lock[l] & ~m_hi[l];
    for (int l = 0; l < NL; l++) begin
      bit b, ev, was_locked, lost;
      int nb;
      b = (h[2*l] == h[2*l+1]);
      ev = v[l] && (m_phase[l] == 1);
      was_locked = m_lock[l];
      lost = 0;
      if (c) m_err[l] = 0;
      else if (v[l] && b && m_phase[l] != 2 && m_err[l] < 255) m_err[l]++;
      m_slip[l] = 0;
      if (m_phase[l] == 0) begin
        m_hdrs[l] = 0; m_bad[l] = 0; m_phase[l] = 1;
      end else if (m_phase[l] == 2) begin
        m_wait[l]--;
        if (m_wait[l] == 0) m_phase[l] = 0;
      end else if (ev) begin
        m_hdrs[l]++;
        if (b) m_bad[l]++;
        if (!was_locked && b) begin
          m_slip[l] = 1; m_phase[l] = 2; m_wait[l] = SLIP_WAIT;
        end else if (was_locked && m_bad[l] >= INVALID_LIMIT) begin
          lost = 1; m_lock[l] = 0; m_slip[l] = 1; m_phase[l] = 2; m_wait[l] = SLIP_WAIT;
        end else if (m_hdrs[l] >= LOCK_COUNT) begin
          m_lock[l] = 1; m_hdrs[l] = 0; m_bad[l] = 0;
        end
      end
      if (!was_locked || lost) begin
        m_age[l] = 0; m_ber[l] = 0; m_hi[l] = 0;
      end else begin
        nb = m_ber[l] + ((ev && b) ? 1 : 0);
        if (nb > BER_LIMIT) nb = BER_LIMIT;
        if (m_age[l] == BER_WINDOW - 1) begin
          m_age[l] = 0; m_ber[l] = 0; m_hi[l] = (nb >= BER_LIMIT);
        end else begin
          m_age[l]++; m_ber[l] = nb;
          if (nb >= BER_LIMIT) m_hi[l] = 1;
        end
      end
    end
    m_link = all_ok;
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      r[l] = m_slip[l];
      r[NL+l] = m_lock[l];
      r[2*NL+l] = m_hi[l];
      r[3*NL+8*l +: 8] = 8'(m_err[l]);
    end
    r[VW-1] = m_link;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // ---- monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [VW-1:0] e;
        e = exp_q.pop_front();
        check("outputs", 64'({link, errc, hiber, lock, slip}), 64'(e));
      end
    end
  end

  // ---- stimulus helpers
  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic drive(input logic [2*NL-1:0] h, input logic [NL-1:0] v, input logic c);
    hdr = h; vld = v; clr = c;
    model_step(h, v, c);
    exp_q.push_back(model_vec());
    @(negedge clk);
  endtask

  // called at a negedge; leaves reset released at a later negedge
  task automatic do_reset(input bit check_zero);
    #2 rst_n = 1'b0;
    #1 if (check_zero) check("async_reset_zero", 64'({link, errc, hiber, lock, slip}), 64'd0);
    model_reset();
    hdr = '0; vld = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // lanes whose bit is set in bad_mask get invalid headers
  task automatic run(input int n, input logic [NL-1:0] bad_mask, input int vld_gap);
    for (int k = 0; k < n; k++) begin
      logic [2*NL-1:0] h;
      logic [NL-1:0] v;
      for (int l = 0; l < NL; l++) h[2*l +: 2] = bad_mask[l] ? bad_hdr() : good_hdr();
      v = (vld_gap > 0 && (k % vld_gap) == vld_gap - 1) ? '0 : '1;
      drive(h, v, 1'b0);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 64'({link, errc, hiber, lock, slip}), 64'd0);
    rst_n = 1'b1;

    // clean lock on every lane
    run(80, '0, 0);
    check("clean_lock", 64'(lock), 64'hF);
    check("clean_link", 64'(link), 64'h1);

    // misaligned start, then valid headers
    do_reset(1'b0);
    run(3, '1, 0);
    run(SLIP_WAIT + 2 + LOCK_COUNT + 4, '0, 0);
    check("relock_after_slip", 64'(lock), 64'hF);

    // loss of lock on lane 0; lane 1 at 1-in-5 invalid keeps lock
    for (int k = 0; k < 300; k++) begin
      logic [2*NL-1:0] h;
      for (int l = 0; l < NL; l++) h[2*l +: 2] = good_hdr();
      if (k >= 10 && k < 50) h[1:0] = bad_hdr();
      if (k % 5 == 0) h[3:2] = bad_hdr();
      drive(h, '1, 1'b0);
    end
    check("lane1_lock_retained", 64'(lock[1]), 64'h1);

    // hi-BER: one invalid header per 64 on lane 0, 16 times
    do_reset(1'b0);
    run(70, '0, 0);
    for (int k = 0; k < 16 * 64; k++) run(1, (k % 64 == 10) ? 4'b0001 : 4'b0000, 0);
    run(4, '0, 0);
    check("hiber_set", 64'(hiber[0]), 64'h1);
    check("hiber_lock_held", 64'(lock[0]), 64'h1);
    check("hiber_link_down", 64'(link), 64'h0);
    run(2 * BER_WINDOW + 1000, '0, 0);
    check("hiber_cleared", 64'(hiber), 64'h0);
    check("hiber_link_up", 64'(link), 64'h1);

    // lane 2 fed 2'b00, valid dropped 1 cycle in 33
    do_reset(1'b0);
    for (int k = 0; k < 200; k++) begin
      logic [2*NL-1:0] h;
      for (int l = 0; l < NL; l++) h[2*l +: 2] = good_hdr();
      h[5:4] = 2'b00;
      drive(h, (k % 33 == 32) ? 4'b0000 : 4'b1111, 1'b0);
    end
    check("multi_lane_lock", 64'(lock), 64'hB);
    check("multi_lane_link", 64'(link), 64'h0);

    // random mix
    for (int k = 0; k < 3000; k++) begin
      logic [2*NL-1:0] h;
      for (int l = 0; l < NL; l++) h[2*l +: 2] = ($urandom_range(0, 99) < 3) ? bad_hdr() : good_hdr();
      drive(h, 4'($urandom), ($urandom_range(0, 199) == 0));
    end

    // saturation, clear priority, reset mid-slip
    do_reset(1'b0);
    run(4500, '1, 0);
    check("err_saturated", 64'(errc), 64'hFFFF_FFFF);
    run(1, '1, 0);
    check("err_stays_saturated", 64'(errc), 64'hFFFF_FFFF);
    begin
      logic [2*NL-1:0] h;
      for (int l = 0; l < NL; l++) h[2*l +: 2] = bad_hdr();
      drive(h, '1, 1'b1);
    end
    check("clear_priority", 64'(errc), 64'h0);
    begin
      bit found;
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
        run(1, '1, 0);
        found = m_slip[0];
      end
      if (!found) begin
        n_cmp++; n_err++;
        $display("FAIL slip_search: no slip within 100 cycles, expected one");
      end
      check("slip_before_reset", 64'(slip[0]), 64'h1);
      do_reset(1'b1);
    end
    run(80, '0, 0);
    check("lock_after_reset", 64'(lock), 64'hF);

    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
